axis_pkt_checker: RTL and testbench
===================================

# axis_pkt_checker

Synthesizable, parametrised AXI4-Stream sink that checks received packets against a queue of expected words, for use on hardware bring-up paths and in simulation without a vendor VIP. Expected words are loaded through a valid/ready port into an internal FIFO. The block drives TREADY with a selectable backpressure pattern and compares every accepted beat on data, TLAST, TDEST and TUSER. It also checks AXI stability rules and reports the first error with sticky status.

## Interface
- DATA_W, 32, width of TDATA and expected words
- DEST_W, 8, width of TDEST; expected dest is bits [DATA_W-1 -: DEST_W] of a packet's first expected word
- USER_W, 4, width of TUSER; bit 0 = first-beat flag, other bits must be 0
- DEPTH, 64, expected-word FIFO depth; power of 2, ≥2
- READY_MODE, 0, 0 = no backpressure, 1 = oscillating TREADY
- LOW_TIME, 1, TREADY low cycles in mode 1 (≥1)
- HIGH_TIME, 2, TREADY high cycles in mode 1 (≥1)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- exp_valid  in  1  expected word valid
- exp_ready  out  1  expected FIFO not full
- exp_data  in  DATA_W  expected word
- exp_last  in  1  word is last of its packet
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tdata  in  DATA_W
- s_axis_tlast  in  1
- s_axis_tdest  in  DEST_W
- s_axis_tuser  in  USER_W
- busy  out  1  FIFO non-empty
- err  out  1  sticky error flag
- err_code  out  3  first error: 1 unexpected beat, 2 data, 3 last, 4 dest, 5 user, 6 stability
- err_beat  out  16  value of beat_count at the first error
- beat_count  out  16  beats accepted since reset, wraps
- pkt_count  out  16  packets completed since reset, wraps

## Operation
- FIFO stores {exp_last, exp_data}. Push on exp_valid & exp_ready. exp_ready = !full, which is independent of a same-cycle pop.
- Handshake = s_axis_tvalid & s_axis_tready. On each handshake the head entry is popped if present, and beat_count increments.
- first flag: set by reset and after any handshake whose popped entry has last=1. Cleared on any other handshake. While first=1, the head's top DEST_W bits are captured into the dest register at the handshake.
- Checks per handshake, priority order 1 > 2 > 3 > 4 > 5:
  - Code 1: FIFO empty.
  - Code 2: tdata ≠ head data.
  - Code 3: tlast ≠ head last.
  - Code 4: tdest ≠ expected dest. On the first beat, expected dest is taken from head data; otherwise it is the dest register.
  - Code 5: tuser ≠ {0…, first}.
- Code 6 (stability): in the previous cycle, tvalid=1 and tready=0, and in this cycle tvalid=0 or any of {tdata, tlast, tdest, tuser} differs. Code 6 overrides the codes above in the same cycle.
- The first error sets err=1 and captures err_code and err_beat. Later errors change nothing until rst. Checking and popping continue after an error.
- pkt_count increments on each handshake whose popped entry has last=1.
- TREADY:
  - Mode 0: 1 every cycle outside reset.
  - Mode 1: a counter produces LOW_TIME low cycles, then HIGH_TIME high cycles, repeating from reset.
  - TREADY does not depend on FIFO state, so stray beats are accepted and flagged.
- rst at any point, including mid-packet, performs the following:
  - flushes the FIFO
  - clears err, err_code, err_beat, the counters and the dest register
  - sets first=1 and the stability history to idle

## Timing
- All outputs are registered except exp_ready and busy, which are decoded from the registered FIFO count.
- Reset values: s_axis_tready=0, err=0, err_code=0, err_beat=0, beat_count=0, pkt_count=0, busy=0, exp_ready=1.
- s_axis_tready:
  - Mode 0: 1 in the first cycle after rst deasserts.
  - Mode 1: low for the first LOW_TIME cycles after reset, then follows the pattern.
- Push in cycle N makes the word matchable by a handshake in cycle N+1. The same word is never matchable in cycle N.
- Push and pop may occur in the same cycle when the FIFO is neither empty nor full. Occupancy is then unchanged.
- err, err_code, err_beat, beat_count and pkt_count update in cycle N+1 for a handshake in cycle N.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.

## Test plan
- Push 0x05000001, 0x00000002, 0x00000003 (last on third). Send 3 beats with tdest=0x05, tuser=1,0,0 and tlast on the third beat. Required: err=0, pkt_count=1, beat_count=3, busy=0.
- Same stimulus but beat 1 carries data 0x00000009. Required: err=1, err_code=2, err_beat=1 one cycle after that handshake. The third beat is still accepted; beat_count=3.
- Send a beat with the FIFO empty. Required: err_code=1, err_beat=0. Then, in a second case, omit tlast on the final beat. Required: err_code=3.
- READY_MODE=1, LOW_TIME=1, HIGH_TIME=2. Required: tready pattern after reset is 0,1,1,0,1,1. Change tdata while tvalid=1 during a low cycle. Required: err_code=6.
- DEPTH=4: four pushes leave exp_ready=0. With 3 entries, push and handshake in the same cycle. Required: occupancy stays 3 and order is preserved.
- Assert rst after beat 2 of a 3-beat packet. Required: all status is cleared. A following packet whose first beat has tuser=1 and a new dest passes with err=0.

Source files
------------

// File: rtl/axis_pkt_checker_if.sv
// AXI4-Stream bundle seen by the packet checker: payload, sideband and handshake.
interface axis_pkt_checker_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 8,
    parameter int USER_W = 4
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport master (output tvalid, tdata, tlast, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tdest, tuser, output tready);
endinterface

// File: rtl/axis_pkt_checker.sv
// AXI4-Stream sink that compares every accepted beat against a FIFO of expected
// words, drives a configurable TREADY pattern, checks stability while stalled,
// and latches the first error it sees.
module axis_pkt_checker #(
    parameter int DATA_W     = 32,
    parameter int DEST_W     = 8,
    parameter int USER_W     = 4,
    parameter int DEPTH      = 64,
    parameter int READY_MODE = 0,
    parameter int LOW_TIME   = 1,
    parameter int HIGH_TIME  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              exp_last,
    axis_pkt_checker_if.slave s_axis,
    output logic              busy,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [15:0]       err_beat,
    output logic [15:0]       beat_count,
    output logic [15:0]       pkt_count
);
    localparam int AW     = $clog2(DEPTH);
    localparam int PERIOD = LOW_TIME + HIGH_TIME;
    localparam int PW     = $clog2(PERIOD + 1);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_UNEXP = 3'd1;
    localparam logic [2:0] ERR_DATA  = 3'd2;
    localparam logic [2:0] ERR_LAST  = 3'd3;
    localparam logic [2:0] ERR_DEST  = 3'd4;
    localparam logic [2:0] ERR_USER  = 3'd5;
    localparam logic [2:0] ERR_STAB  = 3'd6;

    // Expected-word storage: {last, data}
    logic [DATA_W:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              tready_q, tready_d;
    logic              first_q, first_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [15:0]       beat_count_q, beat_count_d, pkt_count_q, pkt_count_d;
    logic              err_q, err_d;
    logic [2:0]        err_code_q, err_code_d;
    logic [15:0]       err_beat_q, err_beat_d;
    logic              stall_q, stall_d;
    logic [DATA_W-1:0] prev_data_q;
    logic              prev_last_q;
    logic [DEST_W-1:0] prev_dest_q;
    logic [USER_W-1:0] prev_user_q;

    logic              full, empty, push, hs, pop, head_last, stab_err;
    logic [DATA_W-1:0] head_data;
    logic [DEST_W-1:0] exp_dest;
    logic [2:0]        beat_code, cur_code;

    assign full      = (count_q == (AW + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign exp_ready = !full;
    assign busy      = !empty;
    assign push      = exp_valid && !full;
    assign hs        = s_axis.tvalid && tready_q;
    assign pop       = hs && !empty;
    assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];
    assign head_last = mem_q[rd_ptr_q][DATA_W];
    assign exp_dest  = first_q ? head_data[DATA_W-1 -: DEST_W] : dest_q;

    // Classify the current beat and the stability rule into one error code
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        beat_code = ERR_NONE;
        if (empty)                                     beat_code = ERR_UNEXP;
        else if (s_axis.tdata != head_data)            beat_code = ERR_DATA;
        else if (s_axis.tlast != head_last)            beat_code = ERR_LAST;
        else if (s_axis.tdest != exp_dest)             beat_code = ERR_DEST;
        else if (s_axis.tuser != USER_W'(first_q))     beat_code = ERR_USER;

        stab_err = stall_q && (!s_axis.tvalid || s_axis.tdata != prev_data_q ||
                               s_axis.tlast != prev_last_q || s_axis.tdest != prev_dest_q ||
                               s_axis.tuser != prev_user_q);

        cur_code = ERR_NONE;
        if (stab_err) cur_code = ERR_STAB;
        else if (hs)  cur_code = beat_code;
    end

    // Next-state for FIFO pointers, ready pattern, packet tracking and status
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        if (push && !pop) count_d = count_q + (AW + 1)'(1);
        if (pop && !push) count_d = count_q - (AW + 1)'(1);

        phase_d  = (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + PW'(1);
        tready_d = (READY_MODE == 0) ? 1'b1 : (phase_q >= PW'(LOW_TIME));

        first_d      = first_q;
        dest_d       = dest_q;
        beat_count_d = beat_count_q;
        pkt_count_d  = pkt_count_q;
        if (hs) begin
            beat_count_d = beat_count_q + 16'd1;
            first_d      = pop && head_last;
            if (pop && first_q) dest_d = head_data[DATA_W-1 -: DEST_W];
            if (pop && head_last) pkt_count_d = pkt_count_q + 16'd1;
        end

        err_d      = err_q;
        err_code_d = err_code_q;
        err_beat_d = err_beat_q;
        if (!err_q && cur_code != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = cur_code;
            err_beat_d = beat_count_q;
        end

        stall_d = s_axis.tvalid && !tready_q;
    end

    // Expected-word memory; contents are don't-care once the pointers reset
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset -- emptiness is defined by the count alone.
        if (push) mem_q[wr_ptr_q] <= {exp_last, exp_data};
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            phase_q      <= '0;
            tready_q     <= 1'b0;
            first_q      <= 1'b1;
            dest_q       <= '0;
            beat_count_q <= '0;
            pkt_count_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_beat_q   <= '0;
            stall_q      <= 1'b0;
            prev_data_q  <= '0;
            prev_last_q  <= 1'b0;
            prev_dest_q  <= '0;
            prev_user_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            tready_q     <= tready_d;
            first_q      <= first_d;
            dest_q       <= dest_d;
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_beat_q   <= err_beat_d;
            stall_q      <= stall_d;
            prev_data_q  <= s_axis.tdata;
            prev_last_q  <= s_axis.tlast;
            prev_dest_q  <= s_axis.tdest;
            prev_user_q  <= s_axis.tuser;
        end
    end

    assign s_axis.tready = tready_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign err_beat      = err_beat_q;
    assign beat_count    = beat_count_q;
    assign pkt_count     = pkt_count_q;
endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed bench: DUT A (no backpressure, DEPTH=4) covers matching and error
// codes 1-5; DUT B (oscillating TREADY) covers the ready pattern and stability.
module tb_axis_pkt_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A signals
    logic        rst_a, exp_valid_a, exp_last_a, exp_ready_a;
    logic [31:0] exp_data_a;
    logic        busy_a, err_a;
    logic [2:0]  err_code_a;
    logic [15:0] err_beat_a, beat_count_a, pkt_count_a;
    axis_pkt_checker_if #(.DATA_W(32), .DEST_W(8), .USER_W(4)) ax_a ();

    // DUT B signals
    logic        rst_b, exp_valid_b, exp_last_b, exp_ready_b;
    logic [31:0] exp_data_b;
    logic        busy_b, err_b;
    logic [2:0]  err_code_b;
    logic [15:0] err_beat_b, beat_count_b, pkt_count_b;
    axis_pkt_checker_if #(.DATA_W(32), .DEST_W(8), .USER_W(4)) ax_b ();

    axis_pkt_checker #(.DEPTH(4), .READY_MODE(0)) dut_a (
        .clk(clk), .rst(rst_a),
        .exp_valid(exp_valid_a), .exp_ready(exp_ready_a), .exp_data(exp_data_a), .exp_last(exp_last_a),
        .s_axis(ax_a.slave),
        .busy(busy_a), .err(err_a), .err_code(err_code_a), .err_beat(err_beat_a),
        .beat_count(beat_count_a), .pkt_count(pkt_count_a)
    );

    axis_pkt_checker #(.READY_MODE(1), .LOW_TIME(1), .HIGH_TIME(2)) dut_b (
        .clk(clk), .rst(rst_b),
        .exp_valid(exp_valid_b), .exp_ready(exp_ready_b), .exp_data(exp_data_b), .exp_last(exp_last_b),
        .s_axis(ax_b.slave),
        .busy(busy_b), .err(err_b), .err_code(err_code_b), .err_beat(err_beat_b),
        .beat_count(beat_count_b), .pkt_count(pkt_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One reset edge, then one more edge so TREADY is already high
    task automatic reset_a();
        rst_a = 1'b1;
        ax_a.tvalid = 1'b0;
        exp_valid_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_a(input logic [31:0] d, input logic l);
        exp_valid_a = 1'b1;
        exp_data_a  = d;
        exp_last_a  = l;
        @(posedge clk); #1;
        exp_valid_a = 1'b0;
    endtask

    task automatic beat_a(input logic [31:0] d, input logic l, input logic [7:0] dest,
                          input logic [3:0] user);
        ax_a.tvalid = 1'b1;
        ax_a.tdata  = d;
        ax_a.tlast  = l;
        ax_a.tdest  = dest;
        ax_a.tuser  = user;
        @(posedge clk); #1;
        ax_a.tvalid = 1'b0;
    endtask

    task automatic push_pkt3();
        push_a(32'h0500_0001, 1'b0);
        push_a(32'h0000_0002, 1'b0);
        push_a(32'h0000_0003, 1'b1);
    endtask

    logic [5:0] tready_pat;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        exp_valid_a = 1'b0; exp_data_a = '0; exp_last_a = 1'b0;
        exp_valid_b = 1'b0; exp_data_b = '0; exp_last_b = 1'b0;
        ax_a.tvalid = 1'b0; ax_a.tdata = '0; ax_a.tlast = 1'b0; ax_a.tdest = '0; ax_a.tuser = '0;
        ax_b.tvalid = 1'b0; ax_b.tdata = '0; ax_b.tlast = 1'b0; ax_b.tdest = '0; ax_b.tuser = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_tready_a", ax_a.tready, 0);
        check("rst_tready_b", ax_b.tready, 0);
        check("rst_busy", busy_a, 0);
        check("rst_exp_ready", exp_ready_a, 1);
        check("rst_err", err_a, 0);
        check("rst_err_code", err_code_a, 0);
        check("rst_err_beat", err_beat_a, 0);
        check("rst_beat_count", beat_count_a, 0);
        check("rst_pkt_count", pkt_count_a, 0);

        // TREADY after reset: mode 0 high at once, mode 1 follows 0,1,1,0,1,1
        rst_a = 1'b0; rst_b = 1'b0;
        tready_pat = 6'b110110;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("tready_mode0_first", ax_a.tready, 1);
            check($sformatf("tready_pat_%0d", i), ax_b.tready, tready_pat[i]);
        end

        // Stability: tdata changes while stalled in a low cycle
        @(posedge clk); #1;
        check("stab_low_cycle", ax_b.tready, 0);
        ax_b.tvalid = 1'b1; ax_b.tdata = 32'hAAAA_0000; ax_b.tuser = 4'h1;
        @(posedge clk); #1;
        check("stab_no_err_yet", err_b, 0);
        check("stab_high_cycle", ax_b.tready, 1);
        ax_b.tdata = 32'hBBBB_0000;
        @(posedge clk); #1;
        ax_b.tvalid = 1'b0;
        check("stab_err", err_b, 1);
        check("stab_err_code", err_code_b, 6);
        check("stab_err_beat", err_beat_b, 0);
        check("stab_beat_count", beat_count_b, 1);

        // Clean 3-beat packet
        reset_a();
        push_pkt3();
        check("p1_busy_loaded", busy_a, 1);
        beat_a(32'h0500_0001, 1'b0, 8'h05, 4'h1);
        beat_a(32'h0000_0002, 1'b0, 8'h05, 4'h0);
        beat_a(32'h0000_0003, 1'b1, 8'h05, 4'h0);
        check("p1_err", err_a, 0);
        check("p1_pkt_count", pkt_count_a, 1);
        check("p1_beat_count", beat_count_a, 3);
        check("p1_busy", busy_a, 0);

        // Data mismatch on beat 1
        reset_a();
        push_pkt3();
        beat_a(32'h0500_0001, 1'b0, 8'h05, 4'h1);
        beat_a(32'h0000_0009, 1'b0, 8'h05, 4'h0);
        check("data_err", err_a, 1);
        check("data_err_code", err_code_a, 2);
        check("data_err_beat", err_beat_a, 1);
        beat_a(32'h0000_0003, 1'b1, 8'h05, 4'h0);
        check("data_beat_count", beat_count_a, 3);
        check("data_err_code_held", err_code_a, 2);

        // Beat with empty FIFO
        reset_a();
        beat_a(32'h1234_5678, 1'b1, 8'h12, 4'h1);
        check("unexp_err_code", err_code_a, 1);
        check("unexp_err_beat", err_beat_a, 0);
        check("unexp_beat_count", beat_count_a, 1);

        // Missing tlast on the final beat
        reset_a();
        push_pkt3();
        beat_a(32'h0500_0001, 1'b0, 8'h05, 4'h1);
        beat_a(32'h0000_0002, 1'b0, 8'h05, 4'h0);
        beat_a(32'h0000_0003, 1'b0, 8'h05, 4'h0);
        check("last_err_code", err_code_a, 3);
        check("last_err_beat", err_beat_a, 2);
        check("last_pkt_count", pkt_count_a, 1);

        // Wrong dest on first beat
        reset_a();
        push_a(32'h0700_0000, 1'b1);
        beat_a(32'h0700_0000, 1'b1, 8'h08, 4'h1);
        check("dest_err_code", err_code_a, 4);

        // Missing first-beat flag in tuser
        reset_a();
        push_a(32'h0700_0000, 1'b1);
        beat_a(32'h0700_0000, 1'b1, 8'h07, 4'h0);
        check("user_err_code", err_code_a, 5);

        // DEPTH=4 occupancy with simultaneous push and pop
        reset_a();
        push_a(32'h0A00_0010, 1'b0);
        push_a(32'h0000_0011, 1'b0);
        push_a(32'h0000_0012, 1'b0);
        check("occ3_exp_ready", exp_ready_a, 1);
        exp_valid_a = 1'b1; exp_data_a = 32'h0000_0013; exp_last_a = 1'b1;
        beat_a(32'h0A00_0010, 1'b0, 8'h0A, 4'h1);
        exp_valid_a = 1'b0;
        check("pushpop_exp_ready", exp_ready_a, 1);
        check("pushpop_beat_count", beat_count_a, 1);
        push_a(32'h0B00_0020, 1'b1);
        check("full_exp_ready", exp_ready_a, 0);
        beat_a(32'h0000_0011, 1'b0, 8'h0A, 4'h0);
        beat_a(32'h0000_0012, 1'b0, 8'h0A, 4'h0);
        beat_a(32'h0000_0013, 1'b1, 8'h0A, 4'h0);
        beat_a(32'h0B00_0020, 1'b1, 8'h0B, 4'h1);
        check("order_err", err_a, 0);
        check("order_pkt_count", pkt_count_a, 2);
        check("order_beat_count", beat_count_a, 5);
        check("order_busy", busy_a, 0);
        check("order_exp_ready", exp_ready_a, 1);

        // Reset mid-packet clears everything; next packet with a new dest passes
        reset_a();
        push_pkt3();
        beat_a(32'h0500_0001, 1'b0, 8'h05, 4'h1);
        beat_a(32'h0000_0002, 1'b0, 8'h05, 4'h3);
        check("mid_err_code", err_code_a, 5);
        reset_a();
        check("mid_rst_err", err_a, 0);
        check("mid_rst_err_code", err_code_a, 0);
        check("mid_rst_err_beat", err_beat_a, 0);
        check("mid_rst_beat_count", beat_count_a, 0);
        check("mid_rst_pkt_count", pkt_count_a, 0);
        check("mid_rst_busy", busy_a, 0);
        push_a(32'h3C00_0001, 1'b0);
        push_a(32'h0000_0002, 1'b1);
        beat_a(32'h3C00_0001, 1'b0, 8'h3C, 4'h1);
        beat_a(32'h0000_0002, 1'b1, 8'h3C, 4'h0);
        check("post_rst_err", err_a, 0);
        check("post_rst_pkt_count", pkt_count_a, 1);
        check("post_rst_beat_count", beat_count_a, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
